// File: rtl/com_flash_host.sv
// Host-side initiator for the UART flash-programming byte protocol (WRITE / READ / ERASE).
// Optional receive timeout is enabled by defining COM_FLASH_HOST_TIMEOUT_EN.
module com_flash_host #(
  parameter int          FLASH_ADDR_SIZE = 22,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd12_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [FLASH_ADDR_SIZE-1:0] cmd_start,
  input  logic [FLASH_ADDR_SIZE-1:0] cmd_end,
  input  logic [15:0]                wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic [15:0]                rd_data,
  output logic                       rd_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_ready,
  output logic                       done,
  output logic [2:0]                 err_code
);
  localparam logic [7:0] CMD_WRITE   = 8'hF0;
  localparam logic [7:0] CMD_READ    = 8'h0F;
  localparam logic [7:0] CMD_ERASE   = 8'h38;
  localparam logic [7:0] IN_PROGRESS = 8'hCC;
  localparam logic [7:0] FINISHED    = 8'h33;
  localparam logic [7:0] SUM_INIT    = 8'h23;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_READ     = 2'b10;
  localparam logic [2:0] ERR_NONE = 3'd0, ERR_META = 3'd1, ERR_SUM = 3'd2,
                         ERR_TMO  = 3'd3, ERR_ERASE = 3'd4, ERR_EMPTY = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_META, S_SEND, S_WAIT_ACK, S_WR_FETCH, S_RD_HI, S_RD_LO, S_WAIT_SUM, S_ERASE_POLL
  } state_t;

  state_t                     r_state, r_ret, w_nxt;
  logic [1:0]                 r_op;
  logic [FLASH_ADDR_SIZE-1:0] r_start, r_end, r_addr;
  logic [2:0]                 r_meta_idx;
  logic [7:0]                 r_sum, r_byte, r_tx_data;
  logic                       r_lo_pend, r_busy_seen, r_wr_ready, r_rd_valid, r_done;
  logic [15:0]                r_rd_data;
  logic [2:0]                 r_err;

  logic                       w_empty, w_wr_hs, w_last, w_tmo;
  logic [FLASH_ADDR_SIZE-1:0] w_addr_inc;
  logic [23:0]                w_start24, w_end24;
  logic [7:0]                 w_meta_byte, w_cmd_byte;

  assign w_empty    = (cmd_op == OP_WRITE || cmd_op == OP_READ) && (cmd_start == cmd_end);
  assign w_wr_hs    = wr_valid && r_wr_ready;
  assign w_addr_inc = r_addr + {{(FLASH_ADDR_SIZE-1){1'b0}}, 1'b1};
  assign w_last     = (w_addr_inc == r_end);
  assign w_start24  = 24'(r_start);
  assign w_end24    = 24'(r_end);

  always_comb begin
    case (r_meta_idx)
      3'd0:    w_meta_byte = w_start24[23:16];
      3'd1:    w_meta_byte = w_start24[15:8];
      3'd2:    w_meta_byte = w_start24[7:0];
      3'd3:    w_meta_byte = w_end24[23:16];
      3'd4:    w_meta_byte = w_end24[15:8];
      default: w_meta_byte = w_end24[7:0];
    endcase
    case (cmd_op)
      OP_WRITE: w_cmd_byte = CMD_WRITE;
      OP_READ:  w_cmd_byte = CMD_READ;
      default:  w_cmd_byte = CMD_ERASE;
    endcase
  end

`ifdef COM_FLASH_HOST_TIMEOUT_EN
  logic [23:0] r_tmo;
  logic        w_wait;
  assign w_wait = r_state inside {S_WAIT_ACK, S_RD_HI, S_RD_LO, S_WAIT_SUM, S_ERASE_POLL};
  assign w_tmo  = w_wait && (r_tmo == TIMEOUT_CYCLES - 24'd1);
  // Restart on every received byte and on every state change, so entry starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       r_tmo <= '0;
    else if (!w_wait || rx_ready || w_nxt != r_state) r_tmo <= '0;
    else                                            r_tmo <= r_tmo + 24'd1;
  end
`else
  logic [23:0] w_unused_tmo;
  assign w_unused_tmo = TIMEOUT_CYCLES;
  assign w_tmo        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:       if (cmd_valid && cmd_op != 2'b00 && !w_empty) w_nxt = S_SEND;
      S_META:       w_nxt = S_SEND;
      S_SEND:       if (r_busy_seen && !tx_busy) w_nxt = r_ret;
      S_WAIT_ACK: begin
        if (rx_ready) begin
          if (rx_data != r_sum)     w_nxt = S_IDLE;
          else if (r_op == OP_WRITE) w_nxt = S_WR_FETCH;
          else if (r_op == OP_READ)  w_nxt = S_RD_HI;
          else                       w_nxt = S_ERASE_POLL;
        end else if (w_tmo) w_nxt = S_IDLE;
      end
      S_WR_FETCH:   if (r_lo_pend || w_wr_hs) w_nxt = S_SEND;
      S_RD_HI: begin
        if (rx_ready)   w_nxt = S_RD_LO;
        else if (w_tmo) w_nxt = S_IDLE;
      end
      S_RD_LO: begin
        if (rx_ready)   w_nxt = w_last ? S_WAIT_SUM : S_RD_HI;
        else if (w_tmo) w_nxt = S_IDLE;
      end
      S_WAIT_SUM:   if (rx_ready || w_tmo) w_nxt = S_IDLE;
      S_ERASE_POLL: begin
        if (rx_ready) begin
          if (rx_data != IN_PROGRESS) w_nxt = S_IDLE;
        end else if (w_tmo) w_nxt = S_IDLE;
      end
      default:      w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    tx_start  = (r_state == S_SEND) && !r_busy_seen;
    tx_data   = r_tx_data;
    wr_ready  = r_wr_ready;
    rd_data   = r_rd_data;
    rd_valid  = r_rd_valid;
    done      = r_done;
    err_code  = r_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ret <= S_IDLE;      r_op <= '0;         r_start <= '0;     r_end <= '0;
      r_addr <= '0;         r_meta_idx <= '0;   r_sum <= '0;       r_byte <= '0;
      r_tx_data <= '0;      r_lo_pend <= 1'b0;  r_busy_seen <= 1'b0;
      r_wr_ready <= 1'b0;   r_rd_valid <= 1'b0; r_rd_data <= '0;
      r_done <= 1'b0;       r_err <= ERR_NONE;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      // A fetched word keeps wr_ready low until its low byte has also gone out.
      r_wr_ready <= (w_nxt == S_WR_FETCH) && !r_lo_pend;
      case (r_state)
        S_IDLE: if (cmd_valid && cmd_op != 2'b00) begin
          r_op       <= cmd_op;
          r_start    <= cmd_start;
          r_end      <= cmd_end;
          r_addr     <= cmd_start;
          r_err      <= w_empty ? ERR_EMPTY : ERR_NONE;
          r_tx_data  <= w_cmd_byte;
          r_ret      <= S_META;
          r_meta_idx <= '0;
          r_sum      <= SUM_INIT;
        end
        S_META: begin
          r_tx_data  <= w_meta_byte;
          r_sum      <= r_sum ^ w_meta_byte;
          r_meta_idx <= r_meta_idx + 3'd1;
          r_ret      <= (r_meta_idx == 3'd5) ? S_WAIT_ACK : S_META;
        end
        S_SEND: begin
          if (!r_busy_seen) begin
            if (tx_busy) r_busy_seen <= 1'b1;
          end else if (!tx_busy) r_busy_seen <= 1'b0;
        end
        S_WAIT_ACK: begin
          if (rx_ready) begin
            if (rx_data == r_sum) r_sum <= SUM_INIT;
            else                  r_err <= ERR_META;
          end else if (w_tmo) r_err <= ERR_TMO;
        end
        S_WR_FETCH: begin
          if (r_lo_pend) begin
            r_tx_data <= r_byte;
            r_lo_pend <= 1'b0;
            r_addr    <= w_addr_inc;
            r_ret     <= w_last ? S_WAIT_SUM : S_WR_FETCH;
          end else if (w_wr_hs) begin
            r_tx_data <= wr_data[15:8];
            r_byte    <= wr_data[7:0];
            r_sum     <= r_sum ^ wr_data[15:8] ^ wr_data[7:0];
            r_lo_pend <= 1'b1;
            r_ret     <= S_WR_FETCH;
          end
        end
        S_RD_HI: begin
          if (rx_ready) begin
            r_byte <= rx_data;
            r_sum  <= r_sum ^ rx_data;
          end else if (w_tmo) r_err <= ERR_TMO;
        end
        S_RD_LO: begin
          if (rx_ready) begin
            r_rd_data  <= {r_byte, rx_data};
            r_rd_valid <= 1'b1;
            r_sum      <= r_sum ^ rx_data;
            r_addr     <= w_addr_inc;
          end else if (w_tmo) r_err <= ERR_TMO;
        end
        S_WAIT_SUM: begin
          if (rx_ready) begin
            if (rx_data == r_sum) r_done <= 1'b1;
            else                  r_err  <= ERR_SUM;
          end else if (w_tmo) r_err <= ERR_TMO;
        end
        S_ERASE_POLL: begin
          if (rx_ready) begin
            if (rx_data == FINISHED)         r_done <= 1'b1;
            else if (rx_data != IN_PROGRESS) r_err  <= ERR_ERASE;
          end else if (w_tmo) r_err <= ERR_TMO;
        end
        default: ;
      endcase
    end
  end
endmodule
